// File: rtl/des_round_sequencer.sv
// Iterative DES engine: IP/PC1 on accept, ROUNDS_PER_CYCLE rounds per RUN cycle, IP^-1 on the final edge.
// Optional `DES_DECRYPT_EN adds a per-block decrypt input that reverses the key schedule.
module des_round_sequencer #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [64:1] in_data,
    input  logic [64:1] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:1] out_data,
    output logic        busy
`ifdef DES_DECRYPT_EN
    ,
    input  logic        decrypt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7};

    localparam int IPINV_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25};

    // Flattened S1..S8, each box as 4 rows x 16 columns
    localparam logic [3:0] SBOX_T [512] = '{
        14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
        15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
        10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
         7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
         2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
        12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
         4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
        13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11};

    // Tables use DES numbering (bit 1 = MSB); vectors are [N-1:0] so DES bit n sits at N-n.
    function automatic logic [63:0] fIp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++)
            y[6'(63 - i)] = x[6'(64 - IP_T[i])];
        return y;
    endfunction

    function automatic logic [63:0] fIpInv(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++)
            y[6'(63 - i)] = x[6'(64 - IPINV_T[i])];
        return y;
    endfunction

    function automatic logic [55:0] fPc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++)
            y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] fPc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++)
            y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] fExpand(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++)
            y[6'(47 - i)] = x[5'(32 - E_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] fPerm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++)
            y[5'(31 - i)] = x[5'(32 - P_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] fSbox(input logic [47:0] x);
        logic [31:0] y;
        logic [5:0]  b;
        y = '0;
        for (int s = 0; s < 8; s++) begin
            b = x[6'(47 - 6 * s) -: 6];
            y = {y[27:0], SBOX_T[9'(64 * s + 16 * int'({b[5], b[0]}) + int'(b[4:1]))]};
        end
        return y;
    endfunction

    // Decrypt walks the schedule backwards: right rotates of 0,1,2,...,1 regenerate K16..K1
    function automatic logic [119:0] fRound(input logic [119:0] st, input logic [4:0] rnd,
                                            input logic dec);
        logic [31:0] l, r;
        logic [27:0] c, d;
        logic        rotOne;
        {l, r, c, d} = st;
        rotOne = (rnd == 5'd1) || (rnd == 5'd2) || (rnd == 5'd9) || (rnd == 5'd16);
        if (!dec) begin
            c = rotOne ? {c[26:0], c[27]} : {c[25:0], c[27:26]};
            d = rotOne ? {d[26:0], d[27]} : {d[25:0], d[27:26]};
        end else if (rnd != 5'd1) begin
            c = rotOne ? {c[0], c[27:1]} : {c[1:0], c[27:2]};
            d = rotOne ? {d[0], d[27:1]} : {d[1:0], d[27:2]};
        end
        return {r, l ^ fPerm(fSbox(fExpand(r) ^ fPc2({c, d}))), c, d};
    endfunction

    state_t        r_state;
    state_t        w_stateNext;
    logic [31:0]   r_l, r_r;
    logic [27:0]   r_c, r_d;
    logic [4:0]    r_cnt;
    logic [63:0]   r_out;
    logic [4:0]    w_cntNext;
    logic          w_last;
    logic          w_accept;
    logic          w_dec;
    logic [63:0]   w_ipIn;
    logic [55:0]   w_pc1Key;
    logic [119:0]  w_stage [ROUNDS_PER_CYCLE + 1];
    logic [119:0]  w_fin;
    logic [63:0]   w_result;

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_cntNext = r_cnt + 5'(ROUNDS_PER_CYCLE);
    assign w_last    = (w_cntNext == 5'd16);
    assign w_ipIn    = fIp(in_data);
    assign w_pc1Key  = fPc1(key);

`ifdef DES_DECRYPT_EN
    logic r_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_dec <= 1'b0;
        else if (w_accept)
            r_dec <= decrypt;
    end

    assign w_dec = r_dec;
`else
    assign w_dec = 1'b0;
`endif

    assign w_stage[0] = {r_l, r_r, r_c, r_d};

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
        assign w_stage[g + 1] = fRound(w_stage[g], r_cnt + 5'(g + 1), w_dec);
    end

    // Final swap: IP^-1 is applied to R16 || L16
    assign w_fin    = w_stage[ROUNDS_PER_CYCLE];
    assign w_result = fIpInv({w_fin[87:56], w_fin[119:88]});

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_stateNext = RUN;
            RUN:     if (w_last)    w_stateNext = DONE;
            DONE:    if (out_ready) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE) && !rst;
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_l   <= '0;
            r_r   <= '0;
            r_c   <= '0;
            r_d   <= '0;
            r_cnt <= '0;
            r_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        {r_l, r_r} <= w_ipIn;
                        {r_c, r_d} <= w_pc1Key;
                        r_cnt      <= '0;
                    end
                end
                RUN: begin
                    {r_l, r_r, r_c, r_d} <= w_fin;
                    r_cnt                <= w_cntNext;
                    if (w_last)
                        r_out <= w_result;
                end
                default: ;
            endcase
        end
    end

    assign out_data = r_out;

endmodule
